// File: rtl/output_buffer_banked.sv
`default_nettype none
// =============================================================================
// output_buffer_banked : banked PEA row buffer with write, saturating accumulate
//                        and single-word drain reads.   Rev 1.0
// =============================================================================
module output_buffer_banked #(
  parameter int NUM_BANKS  = 32,
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = 10,
  parameter int BANK_IDX_W = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pass_start,
  input  logic [1:0]                  mode,
  input  logic                        pea_valid,
  output logic                        pea_ready,
  input  logic [NUM_BANKS*DATA_W-1:0] input_bus,
  input  logic                        ext_rd_en,
  input  logic [BANK_IDX_W-1:0]       memory_bank_index,
  input  logic [ADDR_W-1:0]           memory_bank_address,
  output logic [DATA_W-1:0]           ext_rd_data,
  output logic                        ext_rd_valid,
  output logic [ADDR_W:0]             wr_ptr,
  output logic                        full,
  output logic                        overflow,
  output logic                        sat_flag,
  output logic                        busy
);

  localparam int c_aw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_sel_w = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [ADDR_W:0]     c_depth     = DEPTH[ADDR_W:0];
  localparam logic [BANK_IDX_W:0] c_num_banks = NUM_BANKS[BANK_IDX_W:0];
  localparam logic [DATA_W-1:0]   c_sat_max   = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0]   c_sat_min   = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_ACCUM = 2'b10,
    ST_DRAIN = 2'b11
  } state_t;

  state_t                      state_q, state_d;
  logic [ADDR_W:0]             wr_ptr_q, wr_ptr_d;
  logic                        overflow_q, overflow_d;
  logic                        sat_q, sat_d;
  logic                        busy_q;
  logic [c_aw-1:0]             acc_addr_q;
  logic [NUM_BANKS*DATA_W-1:0] acc_row_q;
  logic                        rd_valid_q;
  logic                        rd_oob_q;
  logic [c_sel_w-1:0]          rd_bank_q;
  logic [DATA_W-1:0]           rd_hold_q;

  logic                        w_full;
  logic                        w_loading;
  logic                        w_beat;
  logic                        w_wr_beat;
  logic                        w_acc_beat;
  logic                        w_ovf_evt;
  logic                        w_drain_ok;
  logic                        w_drain_oob;
  logic                        w_drain_rd;
  logic [c_aw-1:0]             w_rd_addr;
  logic [NUM_BANKS-1:0]        w_lane_sat;
  logic                        w_sat_evt;
  logic [DATA_W-1:0]           w_mem_rd [NUM_BANKS];

  assign w_full     = (wr_ptr_q == c_depth);
  assign w_loading  = (state_q == ST_WRITE) || (state_q == ST_ACCUM);
  assign pea_ready  = w_loading && !w_full;
  assign w_beat     = pea_valid && pea_ready && !pass_start;
  assign w_wr_beat  = w_beat && (state_q == ST_WRITE);
  assign w_acc_beat = w_beat && (state_q == ST_ACCUM);
  assign w_ovf_evt  = pea_valid && w_loading && w_full && !pass_start;

  assign w_drain_ok  = ext_rd_en && !pass_start &&
                       ((state_q == ST_IDLE) || (state_q == ST_DRAIN));
  assign w_drain_oob = ({1'b0, memory_bank_index} >= c_num_banks) ||
                       ({1'b0, memory_bank_address} >= c_depth);
  assign w_drain_rd  = w_drain_ok && !w_drain_oob;

  // The shared read port serves the accumulate pre-read or a drain read;
  // the two never coincide because each is legal only in disjoint states.
  assign w_rd_addr = w_acc_beat ? wr_ptr_q[c_aw-1:0] : memory_bank_address[c_aw-1:0];
  assign w_sat_evt = busy_q && (|w_lane_sat);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      overflow_q <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      overflow_q <= overflow_d;
      sat_q      <= sat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q;
    sat_d      = sat_q;
    if (pass_start) begin
      state_d    = state_t'(mode);
      wr_ptr_d   = '0;
      overflow_d = 1'b0;
      sat_d      = 1'b0;
    end else begin
      if (w_beat)    wr_ptr_d   = wr_ptr_q + (ADDR_W+1)'(1);
      if (w_ovf_evt) overflow_d = 1'b1;
      if (w_sat_evt) sat_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_oob_q   <= 1'b0;
      rd_bank_q  <= '0;
      rd_hold_q  <= '0;
    end else begin
      busy_q     <= w_acc_beat;
      rd_valid_q <= w_drain_ok;
      rd_hold_q  <= ext_rd_data;
      if (w_drain_ok) begin
        rd_oob_q  <= w_drain_oob;
        rd_bank_q <= memory_bank_index[c_sel_w-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc_beat) begin
      acc_addr_q <= wr_ptr_q[c_aw-1:0];
      acc_row_q  <= input_bus;
    end
  end

  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] w_add;
    logic [DATA_W:0]   w_sum;
    logic              w_clamp;
    logic [DATA_W-1:0] w_acc_word;
    logic              w_rd_en;
    logic              w_wr_en;
    logic [c_aw-1:0]   w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;

    assign w_add      = acc_row_q[k*DATA_W +: DATA_W];
    assign w_sum      = {rd_q[DATA_W-1], rd_q} + {w_add[DATA_W-1], w_add};
    // Sign bits disagree exactly when the DATA_W-bit result would wrap.
    assign w_clamp    = w_sum[DATA_W] ^ w_sum[DATA_W-1];
    assign w_acc_word = w_clamp ? (w_sum[DATA_W] ? c_sat_min : c_sat_max)
                                : w_sum[DATA_W-1:0];
    assign w_lane_sat[k] = w_clamp;

    assign w_rd_en   = w_acc_beat ||
                       (w_drain_rd && (memory_bank_index[c_sel_w-1:0] == c_sel_w'(k)));
    assign w_wr_en   = busy_q || w_wr_beat;
    assign w_wr_addr = busy_q ? acc_addr_q : wr_ptr_q[c_aw-1:0];
    assign w_wr_data = busy_q ? w_acc_word : input_bus[k*DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
      if (w_wr_en) mem_q[w_wr_addr] <= w_wr_data;
      if (w_rd_en) rd_q <= mem_q[w_rd_addr];
    end

    assign w_mem_rd[k] = rd_q;
  end : g_bank

  // Data is muxed straight off the bank read register on the valid cycle and
  // held in rd_hold_q afterwards, so accumulate pre-reads cannot disturb it.
  assign ext_rd_data  = rd_valid_q ? (rd_oob_q ? '0 : w_mem_rd[rd_bank_q]) : rd_hold_q;
  assign ext_rd_valid = rd_valid_q;
  assign wr_ptr       = wr_ptr_q;
  assign full         = w_full;
  assign overflow     = overflow_q;
  assign sat_flag     = sat_q;
  assign busy         = busy_q;

endmodule : output_buffer_banked
`default_nettype wire
